unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, synchronous-read 32-bit memory between instruction fetch (IF) and
//  MEM-stage load/store (LS). Sits between the fetch stage / MEM stage and the memory macro.
//  Grants one access per cycle and routes each 1-cycle-latency read response to its owner.
//  Generates per-requester stall signals and drops in-flight fetch responses on branch flush.
// PARAMETERS
//  ADDR_W        32  byte-address width; memory is addressed by word (ADDR_W-2 bits)
//  STARVE_LIMIT  4   max consecutive LS grants while if_req is pending; next grant forced to IF
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  reset         in   1       synchronous, active-high reset
//  if_req        in   1       fetch read request
//  if_addr       in   ADDR_W  fetch byte address; bits [1:0] ignored
//  if_flush      in   1       discard fetch response due next cycle (if_id_flush)
//  if_gnt        out  1       IF request accepted this cycle
//  if_stall      out  1       if_req & ~if_gnt; drives fetch pc_write low
//  if_rvalid     out  1       if_rdata is a fresh response this cycle
//  if_rdata      out  32      fetch read data, held until next if_rvalid
//  ls_req        in   1       load/store request
//  ls_we         in   1       1 = store, 0 = load
//  ls_be         in   4       store byte enables
//  ls_addr       in   ADDR_W  load/store byte address; bits [1:0] ignored
//  ls_wdata      in   32      store data
//  ls_gnt        out  1       LS request accepted this cycle
//  ls_stall      out  1       ls_req & ~ls_gnt
//  ls_rvalid     out  1       load response valid this cycle
//  ls_rdata      out  32      load data, held until next ls_rvalid
//  mem_en        out  1       memory access this cycle
//  mem_we        out  1       memory write
//  mem_be        out  4       memory byte enables (4'hF on reads)
//  mem_addr      out  ADDR_W-2 word address
//  mem_wdata     out  32      write data
//  mem_rdata     in   32      read data, valid the cycle after a read grant
// BEHAVIOUR
//  Reset: resp_owner=OWN_NONE, starve_cnt=0, if_rdata=ls_rdata=0; all outputs 0.
//  Arbitration (combinational, cycle N): LS wins if ls_req, unless if_req && starve_cnt==STARVE_LIMIT.
//  Exactly one of if_gnt/ls_gnt per cycle; mem_en = if_gnt|ls_gnt; mem_* driven from the winner.
//  starve_cnt: +1 on ls_gnt while if_req; clear on if_gnt or ~if_req; saturates at STARVE_LIMIT.
//  resp_owner register (N+1): OWN_IF on IF grant, OWN_LS on LS load grant, else OWN_NONE (stores
//   produce no response).
//  Response (N+1): owner IF -> if_rvalid=1, if_rdata<=mem_rdata; owner LS -> ls_rvalid, ls_rdata.
//  if_flush in cycle N+1 with owner IF: if_rvalid forced 0, if_rdata not updated.
//  if_flush with owner NONE/LS: no effect; LS traffic never affected by flush.
//  Back-to-back: a new grant may issue in the same cycle as a response; throughput 1 access/cycle.
//  Both idle: mem_en=0, no state change except starve_cnt clear.
//  Reset mid-operation: in-flight response dropped, no rvalid after reset.
//  Address: mem_addr = addr[ADDR_W-1:2]; misalignment checks belong to the requesters.
// STRUCTURE
//  common package: typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} mem_owner_type;
//   localparam STARVE_LIMIT_DEFAULT = 4.
//  Single flat module; arbitration, counter and response routing inline; no sub-module.
// TESTING
//  IF only, addr 0x0,0x4,0x8 -> if_gnt every cycle, if_rvalid N+1, if_rdata = mem words 0,1,2.
//  IF+LS load 0x100 same cycle -> ls_gnt, if_stall=1; next cycle if_gnt, ls_rdata=mem[0x40].
//  LS continuous 6 cycles with if_req held, STARVE_LIMIT=4 -> grants LS,LS,LS,LS,IF,LS.
//  IF grant 0x20 then if_flush next cycle -> if_rvalid=0, if_rdata keeps previous value.
//  Store 0x10 be=4'b0011 data 0xAAAA5555 -> mem_we=1, no ls_rvalid; next load reads merged word.
//  reset asserted the cycle after IF grant -> if_rvalid stays 0, all outputs 0, starve_cnt=0.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package unified_mem_arbiter_pkg;

  // Owner of the read response due in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } mem_owner_type;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-macro signals of the unified memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: gnt/stall outputs tell each requester when its request was not taken.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32
);

  // Instruction fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // Load/store side
  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_gnt;
  logic              ls_stall;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;

  // Memory macro side
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_stall, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_stall, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory macro view
  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_stall, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_stall, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous-read memory between fetch (IF) and load/store (LS).
// Latency: grant is combinational; read data returns the cycle after the grant.
// Backpressure: LS has priority; IF is forced through after STARVE_LIMIT consecutive LS wins.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  unified_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  mem_owner_type    resp_owner_q, resp_owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      ls_rdata_q, ls_rdata_d;

  logic if_win;
  logic ls_win;
  logic if_resp;
  logic ls_resp;

  // Byte-offset bits are the requesters' concern; the memory is word addressed.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

  // Pick the winner for this cycle; nothing is granted while reset is held.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!reset) begin
      if (bus.ls_req && !(bus.if_req && (starve_cnt_q == LIMIT))) begin
        ls_win = 1'b1;
      end else if (bus.if_req) begin
        if_win = 1'b1;
      end
    end
  end

  // Drive the memory port from the winner and compute grant/stall outputs.
  always_comb begin
    bus.if_gnt    = if_win;
    bus.ls_gnt    = ls_win;
    bus.if_stall  = !reset && bus.if_req && !if_win;
    bus.ls_stall  = !reset && bus.ls_req && !ls_win;
    bus.mem_en    = if_win || ls_win;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    if (ls_win) begin
      bus.mem_we    = bus.ls_we;
      bus.mem_be    = bus.ls_we ? bus.ls_be : 4'hF;
      bus.mem_addr  = bus.ls_addr[ADDR_W-1:2];
      bus.mem_wdata = bus.ls_wdata;
    end else if (if_win) begin
      bus.mem_be    = 4'hF;
      bus.mem_addr  = bus.if_addr[ADDR_W-1:2];
    end
  end

  // Count LS wins that kept a pending fetch waiting; any fetch win or idle fetch clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ls_win && bus.if_req) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end else if (if_win || !bus.if_req) begin
      starve_cnt_d = '0;
    end
  end

  // Remember who owns next cycle's read data; stores return nothing.
  always_comb begin
    resp_owner_d = OWN_NONE;
    if (if_win) begin
      resp_owner_d = OWN_IF;
    end else if (ls_win && !bus.ls_we) begin
      resp_owner_d = OWN_LS;
    end
  end

  // Route the returning read data; a flushed fetch response is dropped and leaves data held.
  always_comb begin
    if_resp       = !reset && (resp_owner_q == OWN_IF) && !bus.if_flush;
    ls_resp       = !reset && (resp_owner_q == OWN_LS);
    if_rdata_d    = if_resp ? bus.mem_rdata : if_rdata_q;
    ls_rdata_d    = ls_resp ? bus.mem_rdata : ls_rdata_q;
    bus.if_rvalid = if_resp;
    bus.ls_rvalid = ls_resp;
    bus.if_rdata  = reset ? 32'h0 : if_rdata_d;
    bus.ls_rdata  = reset ? 32'h0 : ls_rdata_d;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner_q <= OWN_NONE;
      starve_cnt_q <= '0;
      if_rdata_q   <= 32'h0;
      ls_rdata_q   <= 32'h0;
    end else begin
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for the unified memory arbiter with a small byte-enabled memory model.
// Latency: one vector per clock; responses checked on the following vector.
// Backpressure: grant/stall values are part of every expected record.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32)) bus();

  unified_mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: word i holds 0xD000_0000 + i after reset; synchronous read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hD000_0000 + 32'(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        ifl;
    logic        lsr;
    logic        lwe;
    logic [3:0]  lbe;
    logic [31:0] lsa;
    logic [31:0] lwd;
    logic [5:0]  ctl;   // {if_gnt, ls_gnt, if_stall, ls_stall, mem_en, mem_we}
    logic [29:0] maddr;
    logic [3:0]  mbe;
    logic        irv;
    logic [31:0] ird;
    logic        lrv;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  task automatic addv(input logic rst, input logic ifr, input logic [31:0] ifa, input logic ifl,
                      input logic lsr, input logic lwe, input logic [3:0] lbe,
                      input logic [31:0] lsa, input logic [31:0] lwd, input logic [5:0] ctl,
                      input logic [29:0] maddr, input logic [3:0] mbe, input logic irv,
                      input logic [31:0] ird, input logic lrv, input logic [31:0] lrd);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.ifl = ifl; v.lsr = lsr; v.lwe = lwe;
    v.lbe = lbe; v.lsa = lsa; v.lwd = lwd; v.ctl = ctl; v.maddr = maddr; v.mbe = mbe;
    v.irv = irv; v.ird = ird; v.lrv = lrv; v.lrd = lrd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ifr, input logic [31:0] ifa,
                       input logic ifl, input logic lsr, input logic lwe, input logic [3:0] lbe,
                       input logic [31:0] lsa, input logic [31:0] lwd);
    reset        = rst;
    bus.if_req   = ifr;
    bus.if_addr  = ifa;
    bus.if_flush = ifl;
    bus.ls_req   = lsr;
    bus.ls_we    = lwe;
    bus.ls_be    = lbe;
    bus.ls_addr  = lsa;
    bus.ls_wdata = lwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] pat_starve;
    logic [4:0] pat_after_rst;
    pat_starve    = 6'b010000;  // bit k set: IF expected to win at step k
    pat_after_rst = 5'b10000;

    // rst ifr ifa ifl | lsr lwe lbe lsa lwd | ctl maddr mbe | irv ird | lrv lrd
    addv(1, 1, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b000000, 30'h0,  4'h0, 0, 32'h0,         0, 32'h0);
    addv(0, 0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b000000, 30'h0,  4'h0, 0, 32'h0,         0, 32'h0);
    addv(0, 1, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b100010, 30'h0,  4'hF, 0, 32'h0,         0, 32'h0);
    addv(0, 1, 32'h4,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b100010, 30'h1,  4'hF, 1, 32'hD0000000, 0, 32'h0);
    addv(0, 1, 32'h8,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b100010, 30'h2,  4'hF, 1, 32'hD0000001, 0, 32'h0);
    addv(0, 1, 32'hC,  0, 1, 0, 4'h0, 32'h100, 32'h0,         6'b011010, 30'h40, 4'hF, 1, 32'hD0000002, 0, 32'h0);
    addv(0, 1, 32'hC,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b100010, 30'h3,  4'hF, 0, 32'hD0000002, 1, 32'hD0000040);
    addv(0, 1, 32'h20, 0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b100010, 30'h8,  4'hF, 1, 32'hD0000003, 0, 32'hD0000040);
    addv(0, 0, 32'h0,  1, 0, 0, 4'h0, 32'h0,   32'h0,         6'b000000, 30'h0,  4'h0, 0, 32'hD0000003, 0, 32'hD0000040);
    addv(0, 0, 32'h0,  0, 1, 1, 4'h3, 32'h10,  32'hAAAA5555,  6'b010011, 30'h4,  4'h3, 0, 32'hD0000003, 0, 32'hD0000040);
    addv(0, 0, 32'h0,  0, 1, 0, 4'hF, 32'h10,  32'h0,         6'b010010, 30'h4,  4'hF, 0, 32'hD0000003, 0, 32'hD0000040);
    addv(0, 0, 32'h0,  1, 0, 0, 4'h0, 32'h0,   32'h0,         6'b000000, 30'h0,  4'h0, 0, 32'hD0000003, 1, 32'hD0005555);
    addv(0, 1, 32'h3,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b100010, 30'h0,  4'hF, 0, 32'hD0000003, 0, 32'hD0005555);
    addv(0, 0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   32'h0,         6'b000000, 30'h0,  4'h0, 1, 32'hD0000000, 0, 32'hD0005555);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_rdata = 32'h0;
    repeat (2) next_cycle();

    // Table-driven walk through fetch, load, flush, store and merged-load cases.
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].ifl, vecs[i].lsr, vecs[i].lwe,
            vecs[i].lbe, vecs[i].lsa, vecs[i].lwd);
      @(negedge clk);
      chk("if_gnt",    i, 32'(bus.if_gnt),    32'(vecs[i].ctl[5]));
      chk("ls_gnt",    i, 32'(bus.ls_gnt),    32'(vecs[i].ctl[4]));
      chk("if_stall",  i, 32'(bus.if_stall),  32'(vecs[i].ctl[3]));
      chk("ls_stall",  i, 32'(bus.ls_stall),  32'(vecs[i].ctl[2]));
      chk("mem_en",    i, 32'(bus.mem_en),    32'(vecs[i].ctl[1]));
      chk("mem_we",    i, 32'(bus.mem_we),    32'(vecs[i].ctl[0]));
      chk("mem_addr",  i, 32'(bus.mem_addr),  32'(vecs[i].maddr));
      chk("mem_be",    i, 32'(bus.mem_be),    32'(vecs[i].mbe));
      chk("if_rvalid", i, 32'(bus.if_rvalid), 32'(vecs[i].irv));
      chk("if_rdata",  i, bus.if_rdata,       vecs[i].ird);
      chk("ls_rvalid", i, 32'(bus.ls_rvalid), 32'(vecs[i].lrv));
      chk("ls_rdata",  i, bus.ls_rdata,       vecs[i].lrd);
      next_cycle();
    end

    // Starvation: both requesting for six cycles -> LS,LS,LS,LS,IF,LS.
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 32'h0, 0, 1, 0, 4'hF, 32'h100, 32'h0);
      @(negedge clk);
      chk("starve_if_gnt",   k, 32'(bus.if_gnt),   32'(pat_starve[k]));
      chk("starve_ls_gnt",   k, 32'(bus.ls_gnt),   32'(!pat_starve[k]));
      chk("starve_if_stall", k, 32'(bus.if_stall), 32'(!pat_starve[k]));
      next_cycle();
    end

    // Idle clears the counter, then three LS wins build it up to 3.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h0, 0, 1, 0, 4'hF, 32'h100, 32'h0);
      @(negedge clk);
      chk("build_ls_gnt", k, 32'(bus.ls_gnt), 32'h1);
      next_cycle();
    end

    // Reset with an LS load in flight: everything quiet, response dropped.
    drive(1, 1, 32'h0, 0, 1, 0, 4'hF, 32'h100, 32'h0);
    @(negedge clk);
    chk("rst_ls_rvalid", 0, 32'(bus.ls_rvalid), 32'h0);
    chk("rst_ls_gnt",    0, 32'(bus.ls_gnt),    32'h0);
    chk("rst_if_gnt",    0, 32'(bus.if_gnt),    32'h0);
    chk("rst_if_stall",  0, 32'(bus.if_stall),  32'h0);
    chk("rst_ls_stall",  0, 32'(bus.ls_stall),  32'h0);
    chk("rst_mem_en",    0, 32'(bus.mem_en),    32'h0);
    chk("rst_ls_rdata",  0, bus.ls_rdata,       32'h0);
    chk("rst_if_rdata",  0, bus.if_rdata,       32'h0);
    next_cycle();

    // Counter must restart from zero: four LS wins before IF is forced.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 32'h0, 0, 1, 0, 4'hF, 32'h100, 32'h0);
      @(negedge clk);
      if (k == 0) chk("post_rst_ls_rvalid", k, 32'(bus.ls_rvalid), 32'h0);
      chk("post_rst_if_gnt", k, 32'(bus.if_gnt), 32'(pat_after_rst[k]));
      chk("post_rst_ls_gnt", k, 32'(bus.ls_gnt), 32'(!pat_after_rst[k]));
      next_cycle();
    end

    // IF grant followed by reset: fetch response never appears.
    drive(0, 1, 32'h20, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("pre_rst_if_gnt", 0, 32'(bus.if_gnt), 32'h1);
    next_cycle();
    drive(1, 1, 32'h24, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_if_rvalid", 1, 32'(bus.if_rvalid), 32'h0);
    chk("rst_if_gnt",    1, 32'(bus.if_gnt),    32'h0);
    chk("rst_if_stall",  1, 32'(bus.if_stall),  32'h0);
    chk("rst_mem_en",    1, 32'(bus.mem_en),    32'h0);
    chk("rst_if_rdata",  1, bus.if_rdata,       32'h0);
    next_cycle();
    drive(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("after_rst_if_rvalid", 2, 32'(bus.if_rvalid), 32'h0);
    chk("after_rst_ls_rvalid", 2, 32'(bus.ls_rvalid), 32'h0);
    chk("after_rst_if_rdata",  2, bus.if_rdata,       32'h0);
    chk("after_rst_ls_rdata",  2, bus.ls_rdata,       32'h0);
    chk("after_rst_mem_en",    2, 32'(bus.mem_en),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
